// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM state codes, ROM entry
// layout, octave codes and note constants.
package song_sequencer_pkg;

    // FSM state codes
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
    localparam logic [ST_W-1:0] ST_SOUND = 3'd2;
    localparam logic [ST_W-1:0] ST_GAP   = 3'd3;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

    // ROM entry layout: {note[3:0], octave[1:0], beats[3:0]}
    localparam int unsigned ENTRY_W   = 10;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned OCT_W     = 2;
    localparam int unsigned BEATS_W   = 4;
    localparam int unsigned NOTE_LSB  = 6;
    localparam int unsigned OCT_LSB   = 4;
    localparam int unsigned BEATS_LSB = 0;

    // ROM address: {song[1:0], index[4:0]}
    localparam int unsigned SONG_W = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ADDR_W = SONG_W + IDX_W;

    // Octave codes
    localparam logic [OCT_W-1:0] OCT_NORMAL     = 2'b00;
    localparam logic [OCT_W-1:0] OCT_UP         = 2'b01;
    localparam logic [OCT_W-1:0] OCT_DOWN       = 2'b10;
    localparam logic [OCT_W-1:0] OCT_NORMAL_ALT = 2'b11;

    // Note constants
    localparam logic [NOTE_W-1:0] NOTE_SIL = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO  = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI  = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_SOL = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA  = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_SI  = 4'd7;

    // Pack one ROM entry
    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic [NOTE_W-1:0]  note,
        input logic [OCT_W-1:0]   oct,
        input logic [BEATS_W-1:0] beats
    );
        return {note, oct, beats};
    endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// song_rom: synchronous song ROM, 4 songs x 32 entries x 10 bits.
// Ports: clk; addr = {song, index}; rd_data valid one cycle after addr.
module song_rom
    import song_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] data_d;
    logic [ENTRY_W-1:0] data_q;

    // Song table; entries left at zero have beats = 0 and end the song
    always_comb begin
        data_d = '0;
        case (addr[ADDR_W-1:IDX_W])
            2'd0: begin
                if (addr[IDX_W-1:0] == 5'd0) data_d = make_entry(NOTE_DO, OCT_NORMAL, 4'd2);
            end
            2'd1: begin
                // All 32 entries play: note cycles do..si, octave cycles all codes
                data_d = make_entry(4'(addr[IDX_W-1:0] % 5'd7) + NOTE_DO,
                                    addr[OCT_W-1:0], 4'd1);
            end
            2'd2: begin
                case (addr[IDX_W-1:0])
                    5'd0:    data_d = make_entry(NOTE_MI,  OCT_UP,         4'd1);
                    5'd1:    data_d = make_entry(NOTE_SOL, OCT_DOWN,       4'd3);
                    5'd2:    data_d = make_entry(NOTE_SI,  OCT_NORMAL_ALT, 4'd2);
                    default: data_d = '0;
                endcase
            end
            default: begin
                case (addr[IDX_W-1:0])
                    5'd0:    data_d = make_entry(NOTE_RE, OCT_NORMAL, 4'd15);
                    5'd1:    data_d = make_entry(NOTE_LA, OCT_UP,     4'd1);
                    5'd2:    data_d = make_entry(NOTE_FA, OCT_DOWN,   4'd1);
                    default: data_d = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rd_data = data_q;

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: plays ROM songs to the buzzer, yielding to live keyboard
// notes (HOLD) and to stop requests.
// Ports: clk, reset (sync, active-high); play_btn/stop_btn level buttons;
// song_sel sampled at start; live_note/live_octave_* keyboard path;
// note_out/octave_* to buzzer; playing = not IDLE; progress = entry index.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned SONG_LEN    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_btn,
    input  logic        stop_btn,
    input  logic [1:0]  song_sel,
    input  logic [3:0]  live_note,
    input  logic        live_octave_up,
    input  logic        live_octave_down,
    output logic [3:0]  note_out,
    output logic        octave_up,
    output logic        octave_down,
    output logic        playing,
    output logic [4:0]  progress
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [ST_W-1:0]   ret_state_q, ret_state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              play_q, stop_q;

    logic              play_edge, stop_edge, live_active;
    logic [ENTRY_W-1:0] rom_data;
    logic [NOTE_W-1:0]  rom_note;
    logic [OCT_W-1:0]   rom_oct;
    logic [BEATS_W-1:0] rom_beats;
    logic [CNT_W-1:0]   sound_len;

    assign play_edge   = play_btn & ~play_q;
    assign stop_edge   = stop_btn & ~stop_q;
    assign live_active = (live_note != NOTE_SIL);

    // Addressed with next-state values so the entry is ready in FETCH
    song_rom u_rom (
        .clk     (clk),
        .addr    ({song_d, index_d}),
        .rd_data (rom_data)
    );

    assign rom_note  = rom_data[NOTE_LSB +: NOTE_W];
    assign rom_oct   = rom_data[OCT_LSB +: OCT_W];
    assign rom_beats = rom_data[BEATS_LSB +: BEATS_W];
    assign sound_len = CNT_W'(rom_beats) * CNT_W'(BEAT_CYCLES);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        index_d     = index_q;
        counter_d   = counter_q;
        song_d      = song_q;
        if (stop_edge) begin
            state_d   = ST_IDLE;
            index_d   = '0;
            counter_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play_edge) begin
                        song_d    = song_sel;
                        index_d   = '0;
                        counter_d = '0;
                        state_d   = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    counter_d = '0;
                    state_d   = (rom_beats == '0) ? ST_IDLE : ST_SOUND;
                end
                ST_SOUND: begin
                    if (live_active) begin
                        ret_state_d = ST_SOUND;
                        state_d     = ST_HOLD;
                    end else if (counter_q == sound_len - CNT_W'(1)) begin
                        counter_d = '0;
                        state_d   = ST_GAP;
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (live_active) begin
                        ret_state_d = ST_GAP;
                        state_d     = ST_HOLD;
                    end else if (counter_q == GAP_LAST) begin
                        counter_d = '0;
                        if (index_q == IDX_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            index_d = index_q + IDX_W'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!live_active) state_d = ret_state_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ret_state_q <= ST_IDLE;
            index_q     <= '0;
            counter_q   <= '0;
            song_q      <= '0;
            play_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            index_q     <= index_d;
            counter_q   <= counter_d;
            song_q      <= song_d;
            play_q      <= play_btn;
            stop_q      <= stop_btn;
        end
    end

    // Buzzer mux. A live key pressed during SOUND/GAP wins on the very cycle
    // it appears, so the keyboard note is heard for exactly as long as held.
    always_comb begin
        note_out    = NOTE_SIL;
        octave_up   = 1'b0;
        octave_down = 1'b0;
        if ((state_q == ST_IDLE) || (state_q == ST_HOLD) ||
            (((state_q == ST_SOUND) || (state_q == ST_GAP)) && live_active)) begin
            note_out    = live_note;
            octave_up   = live_octave_up;
            octave_down = live_octave_down;
        end else if (state_q == ST_SOUND) begin
            note_out    = rom_note;
            octave_up   = (rom_oct == OCT_UP);
            octave_down = (rom_oct == OCT_DOWN);
        end
    end

    assign playing  = (state_q != ST_IDLE);
    assign progress = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2: per-cycle
// comparison against a timeline model plus literal checks per scenario.
module tb_song_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int LEN  = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic [3:0] live_note = 4'd0;
    logic       live_up = 1'b0;
    logic       live_down = 1'b0;
    logic [3:0] note_out;
    logic       octave_up, octave_down, playing;
    logic [4:0] progress;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    song_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(LEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .play_btn         (play_btn),
        .stop_btn         (stop_btn),
        .song_sel         (song_sel),
        .live_note        (live_note),
        .live_octave_up   (live_up),
        .live_octave_down (live_down),
        .note_out         (note_out),
        .octave_up        (octave_up),
        .octave_down      (octave_down),
        .playing          (playing),
        .progress         (progress)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Song contents as written down for the bench: note, octave code, beats
    function automatic void ref_entry(input int s, input int i, output int n, output int o, output int b);
        n = 0; o = 0; b = 0;
        case (s)
            0: if (i == 0) begin n = 1; o = 0; b = 2; end
            1: begin n = (i % 7) + 1; o = i % 4; b = 1; end
            2: case (i)
                   0: begin n = 3; o = 1; b = 1; end
                   1: begin n = 5; o = 2; b = 3; end
                   2: begin n = 7; o = 3; b = 2; end
                   default: ;
               endcase
            default: case (i)
                   0: begin n = 2; o = 0; b = 15; end
                   1: begin n = 6; o = 1; b = 1; end
                   2: begin n = 4; o = 2; b = 1; end
                   default: ;
               endcase
        endcase
    endfunction

    // Model: each entry is a timeline of positions 0 (fetch), 1..D (sound),
    // D+1..D+GAP (gap); a held live key freezes the position.
    bit m_act = 0, m_hold = 0, m_pp = 0, m_ps = 0;
    int m_idx = 0, m_song = 0, m_pos = 0;

    initial begin
        int n, o, b, d, en, eu, ed;
        bit pe, se;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ref_entry(m_song, m_idx, n, o, b);
            d = b * BEAT;
            if (!m_act || m_hold || (m_pos > 0 && live_note != 4'd0)) begin
                en = int'(live_note); eu = int'(live_up); ed = int'(live_down);
            end else if (m_pos >= 1 && m_pos <= d) begin
                en = n; eu = (o == 1) ? 1 : 0; ed = (o == 2) ? 1 : 0;
            end else begin
                en = 0; eu = 0; ed = 0;
            end
            check("playing", 32'(playing), 32'(m_act));
            check("progress", 32'(progress), 32'(m_idx));
            check("note_out", 32'(note_out), 32'(en));
            check("octave_up", 32'(octave_up), 32'(eu));
            check("octave_down", 32'(octave_down), 32'(ed));
            // advance to what the next clock edge produces
            if (reset) begin
                m_act = 0; m_hold = 0; m_idx = 0; m_song = 0; m_pos = 0; m_pp = 0; m_ps = 0;
            end else begin
                pe = play_btn && !m_pp;
                se = stop_btn && !m_ps;
                m_pp = play_btn;
                m_ps = stop_btn;
                if (se) begin
                    m_act = 0; m_hold = 0; m_idx = 0; m_pos = 0;
                end else if (!m_act) begin
                    if (pe) begin m_act = 1; m_song = int'(song_sel); m_idx = 0; m_pos = 0; end
                end else if (m_pos == 0) begin
                    if (b == 0) m_act = 0; else m_pos = 1;
                end else if (m_hold) begin
                    if (live_note == 4'd0) m_hold = 0;
                end else if (live_note != 4'd0) begin
                    m_hold = 1;
                end else if (m_pos == d + GAP) begin
                    if (m_idx == LEN - 1) m_act = 0;
                    else begin m_idx++; m_pos = 0; end
                end else begin
                    m_pos++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_play();
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
    endtask

    // Play one song from the FETCH cycle until playing drops.
    // act 1: live note 5 for len cycles from cycle at; act 2: play edge and song_sel change at cycle at.
    task automatic run_song(input int sel, input int act, input int at, input int len, input int watch,
                            output int plays, output int hits, output int hits5);
        bit done;
        done = 0; plays = 0; hits = 0; hits5 = 0;
        song_sel = 2'(sel);
        pulse_play();
        for (int k = 0; k < 400; k++) begin
            if (act == 1) live_note = (k >= at && k < at + len) ? 4'd5 : 4'd0;
            if (act == 2 && k == at) begin play_btn = 1'b1; song_sel = 2'd3; end
            if (act == 2 && k == at + 1) play_btn = 1'b0;
            @(negedge clk);
            if (!playing) begin done = 1; break; end
            plays++;
            if (int'(note_out) == watch) hits++;
            if (note_out == 4'd5) hits5++;
            tick();
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL run_bound song %0d: still playing after 400 cycles, expected idle", sel);
        end
        live_note = 4'd0;
        play_btn = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int plays, hits, hits5;
        bit seen, found;
        tick(); tick();
        @(negedge clk);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_progress", 32'(progress), 32'd0);
        check("rst_note", 32'(note_out), 32'd0);
        reset = 1'b0;
        tick();

        // IDLE pass-through
        live_note = 4'd6; live_up = 1'b1;
        @(negedge clk);
        check("idle_pass_note", 32'(note_out), 32'd6);
        check("idle_pass_up", 32'(octave_up), 32'd1);
        tick();
        live_note = 4'd0; live_up = 1'b0;
        tick();

        // Song 0: fetch, 8 sound, 2 gap, fetch of end marker
        run_song(0, 0, 0, 0, 1, plays, hits, hits5);
        check("s0_playing_cycles", 32'(plays), 32'd12);
        check("s0_note1_cycles", 32'(hits), 32'd8);

        // Live note 5 for 3 cycles mid-SOUND, song note still totals 8
        run_song(0, 1, 3, 3, 1, plays, hits, hits5);
        check("hold_live_cycles", 32'(hits5), 32'd3);
        check("hold_song_cycles", 32'(hits), 32'd8);
        check("hold_playing_cycles", 32'(plays), 32'd16);

        // Play edge and song_sel change during playback are ignored
        run_song(2, 2, 2, 0, 3, plays, hits, hits5);
        check("noreplay_playing", 32'(plays), 32'd34);
        check("noreplay_note3", 32'(hits), 32'd4);
        check("noreplay_note5", 32'(hits5), 32'd12);

        // Full 32-entry song ends without wrapping
        run_song(1, 0, 0, 0, 1, plays, hits, hits5);
        check("full_playing", 32'(plays), 32'd224);
        check("full_note1", 32'(hits), 32'd20);
        check("full_note5", 32'(hits5), 32'd16);
        @(negedge clk);
        check("full_end_progress", 32'(progress), 32'd31);
        tick();

        // Stop during GAP of entry 3, then restart from entry 0
        song_sel = 2'd1;
        pulse_play();
        seen = 0; found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (progress == 5'd3 && note_out != 4'd0) seen = 1;
            if (seen && note_out == 4'd0) begin found = 1; break; end
            tick();
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL gap_wait: entry 3 gap not reached, progress %0d", progress);
        end
        tick();
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        @(negedge clk);
        check("stop_playing", 32'(playing), 32'd0);
        check("stop_progress", 32'(progress), 32'd0);
        tick();
        pulse_play();
        @(negedge clk);
        check("restart_playing", 32'(playing), 32'd1);
        check("restart_progress", 32'(progress), 32'd0);
        tick();
        @(negedge clk);
        check("restart_note", 32'(note_out), 32'd1);
        tick();
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        tick();

        // Reset mid-SOUND with live note 3 held
        song_sel = 2'd3;
        pulse_play();
        tick(); tick(); tick();
        live_note = 4'd3;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_playing", 32'(playing), 32'd0);
        check("midrst_progress", 32'(progress), 32'd0);
        check("midrst_note", 32'(note_out), 32'd3);
        tick();
        reset = 1'b0;
        live_note = 4'd0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 The block SHALL have parameter BEAT_CYCLES, default 25_000_000, giving clk cycles per beat (250 ms at 100 MHz).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2_500_000, giving the silent clk cycles between consecutive song notes.
REQ-003 The block SHALL have parameter SONG_LEN, default 32, giving the entries per song (maximum 32).
REQ-004 clk  input  1  the single system clock.
REQ-005 reset  input  1  reset; synchronous, active-high.
REQ-006 play_btn  input  1  level input; a rising edge requests playback.
REQ-007 stop_btn  input  1  level input; a rising edge aborts playback.
REQ-008 song_sel  input  2  song number, sampled only at start.
REQ-009 live_note  input  4  note from the keyboard path; 0 = silence, 1..7 = do..si.
REQ-010 live_octave_up, live_octave_down  input  1 each  octave request from the keyboard path.
REQ-011 note_out  output  4  note to the Buzzer.
REQ-012 octave_up, octave_down  output  1 each  octave to the Buzzer.
REQ-013 playing  output  1  high in any state other than IDLE.
REQ-014 progress  output  5  index of the current song entry.

Function
REQ-015 The ROM entry SHALL be 10 bits wide: note[3:0], octave[1:0] (01 = up, 10 = down, 00 = normal, 11 = normal), beats[3:0]; beats = 0 marks end of song.
REQ-016 The FSM SHALL have exactly these states: IDLE, FETCH, SOUND, GAP, HOLD.
REQ-017 Edge detection SHALL register each button once, and an edge SHALL be seen one cycle after the input rises.
REQ-018 IDLE + play edge SHALL latch song_sel, clear the index to 0 and enter FETCH on the next cycle.
REQ-019 FETCH SHALL last exactly 1 cycle, covering the synchronous ROM latency, and SHALL then go to IDLE if beats = 0, otherwise to SOUND.
REQ-020 SOUND SHALL drive the ROM note and octave for exactly beats*BEAT_CYCLES cycles and then enter GAP.
REQ-021 GAP SHALL output silence for GAP_CYCLES cycles.
REQ-022 At the end of GAP, an index of SONG_LEN-1 SHALL go to IDLE; otherwise the index SHALL be incremented and the FSM SHALL enter FETCH.
REQ-023 A live_note != 0 in SOUND or GAP SHALL move the FSM to HOLD, freezing the cycle counter and the index.
REQ-024 In HOLD, note_out and the octave outputs SHALL pass the live inputs through on the same cycle (combinational).
REQ-025 HOLD SHALL return to the saved state on the first cycle with live_note = 0, and the counter SHALL resume from its frozen value.
REQ-026 In IDLE, the live inputs SHALL pass through combinationally.
REQ-027 In FETCH, note_out SHALL be 0 and both octave outputs SHALL be 0.
REQ-028 A stop edge in any state SHALL force IDLE and index 0 on the next cycle; stop has priority over play and over live input.
REQ-029 A play edge outside IDLE SHALL be ignored, and song_sel changes during playback SHALL be ignored.
REQ-030 The cycle counter SHALL be 32 bits wide, and beats*BEAT_CYCLES SHALL be computed at 32-bit width without overflow for beats ≤ 15.
REQ-031 progress SHALL equal the index in every state, and SHALL be 0 after reset and after a stop.

Reset
REQ-032 Reset SHALL force: IDLE, index 0, counter 0, latched song 0, edge registers 0, playing 0, progress 0.
REQ-033 Reset SHALL override stop, play and live inputs in the same cycle, including when reset is asserted mid-note.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the ROM entry field offsets, the octave codes and the note constants 0..7.
REQ-035 Sub-module song_rom SHALL be a synchronous ROM: 4 songs x 32 entries x 10 bits, address {song, index}, 1-cycle read latency.

Verification
REQ-036 Run with BEAT_CYCLES=4 and GAP_CYCLES=2. Entry 0 of song 0 is {note 1, octave 00, 2 beats} and entry 1 is beats 0. A play edge -> playing=1, note_out=1 for 8 cycles, 0 for 2 cycles, then IDLE with playing=0.
REQ-037 Drive live_note=5 for 3 cycles mid-SOUND -> note_out=5 for those 3 cycles, then the song note resumes and the total SOUND time is still 8 cycles.
REQ-038 Apply a stop edge during GAP of entry 3 -> IDLE and progress=0 one cycle after the edge is seen; a subsequent play restarts at entry 0.
REQ-039 Apply a play edge during SOUND and change song_sel during playback -> no restart and no change of song.
REQ-040 Use a song with all 32 entries nonzero -> after entry 31's GAP, return to IDLE with no wrap to entry 0.
REQ-041 Assert reset in mid-SOUND with live_note=3 -> next cycle IDLE, progress=0, note_out=3 (IDLE pass-through).
